udp_rx_probe_monitor: RTL and testbench
=======================================

Name: udp_rx_probe_monitor

Overview:
- Passive monitor on the UDP receive byte stream.
- Parses the 8-byte UDP header, counts payload bytes and checks them against the header length field.
- Registers four debug signals that feed the on-chip logic-analyser core directly downstream: 24-bit byte count, 12-bit good-packet count, 12-bit last payload length, 1-bit bad-packet trigger.
- Never back-pressures the stream.

Parameters:
- HDR_BYTES, 8, UDP header length in bytes.
- LEN_HI_IDX, 4, header byte index of the length MSB; the LSB is at LEN_HI_IDX+1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  byte qualifier; a beat is a cycle with rx_valid=1.
- rx_data  in  8  stream byte, valid when rx_valid=1.
- rx_last  in  1  marks the final beat of a packet; ignored when rx_valid=0.
- rx_err  in  1  MAC/IP error flag; sampled on any valid beat.
- stat_clr  in  1  synchronous clear of probe0, probe1 and probe2.
- probe0  out  24  total accepted bytes, wraps modulo 2^24.
- probe1  out  12  good packet count, wraps modulo 4096.
- probe2  out  12  payload length of the last good packet, saturated at 4095.
- probe3  out  1  one-cycle pulse per bad packet.

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0; FSM goes to S_HDR.
  - hdr_idx=0, pay_cnt=0, len_reg=0, err_seen=0.
- FSM states: S_HDR, S_PAY, S_DROP.
- S_HDR:
  - Each beat increments hdr_idx.
  - Byte LEN_HI_IDX is stored to len_reg[15:8]; byte LEN_HI_IDX+1 to len_reg[7:0].
  - On the beat with hdr_idx=HDR_BYTES-1, go to S_PAY with pay_cnt=0.
  - rx_last before header completion is a runt packet: bad; return to S_HDR with hdr_idx=0.
- S_PAY:
  - Each beat increments pay_cnt (16-bit, saturating at 65535).
  - On the rx_last beat, the packet is good only if all of these hold: rx_err never seen in the packet, len_reg ≥ 8, and pay_cnt_including_this_beat = len_reg − 8.
  - Otherwise the packet is bad.
  - Return to S_HDR.
- Header ending exactly on rx_last (len field = 8, zero payload): the packet is good if len_reg=8 and no error; otherwise bad. The payload length is 0.
- rx_err on a non-last beat:
  - Set err_seen and go to S_DROP.
  - S_DROP counts bytes into probe0 only; rx_last → bad → S_HDR.
- rx_err on the last beat: the packet is bad.
- probe0 increments on every beat, in all states.
- Good end: probe1 increments and probe2 ← min(payload, 4095).
- Bad end: probe3 = 1 for exactly one cycle.
- Timing: all outputs are registered and change on the edge that samples the beat, so they are visible the cycle after the beat is presented.
- rx_valid=0: no state change. Gaps between beats are legal in any state.
- stat_clr=1:
  - probe0, probe1 and probe2 load 0 on that edge. Clear wins over a simultaneous beat, so that beat's byte is not counted.
  - A simultaneous good end is not counted.
  - A simultaneous bad end still pulses probe3.
  - The FSM is unaffected.
- Reset mid-packet: the partial packet is discarded with no probe3 pulse. The first beat after reset is header byte 0.

Decomposition:
- Package udp_probe_pkg:
  - state enum {S_HDR, S_PAY, S_DROP}.
  - Constants UDP_HDR_BYTES=8, PROBE0_W=24, PROBE_CNT_W=12, PAY_CNT_W=16.
- One sub-module, udp_hdr_len_capture: holds hdr_idx, the length-field capture and the header-done strobe.
- Counters, comparison and probe registers stay in the top module.

Test Plan:
- Good packet: header with len=0x000C and 4 payload bytes, rx_last on the 12th beat → probe0=12, probe1=1, probe2=4, probe3 never pulses.
- Length mismatch: len=0x0010 with 3 payload bytes → probe3 pulses once, one cycle after rx_last; probe1=0, probe2 unchanged, probe0=11.
- Runt and error:
  - A 5-byte packet → probe3 pulses.
  - Next, a packet with rx_err on payload beat 2 and len otherwise correct → second probe3 pulse; the S_DROP bytes are still counted in probe0.
- Wrap and saturate:
  - Preload via 4096 good zero-payload packets → probe1 wraps to 0.
  - A 5000-byte-payload good packet → probe2=4095.
- stat_clr on the same cycle as a good rx_last → probe0, probe1 and probe2 all read 0 next cycle; the following good packet gives probe1=1.
- Async reset mid-payload with random rx_valid gaps → outputs 0 immediately and no probe3 pulse; the next full good packet is counted correctly.

Source files
------------

// File: rtl/udp_probe_pkg.sv
// Shared types and constants for the UDP receive probe monitor.
//   state_e   : parser state (header, payload, drop-until-last)
//   widths    : probe and counter widths used by the monitor and its capture block
//   sat_probe : clamps a 16-bit payload count to the 12-bit probe range
package udp_probe_pkg;

  localparam int unsigned UDP_HDR_BYTES = 8;
  localparam int unsigned PROBE0_W      = 24;
  localparam int unsigned PROBE_CNT_W   = 12;
  localparam int unsigned PAY_CNT_W     = 16;
  localparam int unsigned LEN_W         = 16;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  // Payload length as seen by the analyser: saturates at the 12-bit maximum.
  function automatic logic [PROBE_CNT_W-1:0] sat_probe(input logic [PAY_CNT_W-1:0] n);
    logic [PAY_CNT_W-1:0] max_v;
    max_v = PAY_CNT_W'((1 << PROBE_CNT_W) - 1);
    if (n > max_v) begin
      return '1;
    end
    return n[PROBE_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/udp_hdr_len_capture.sv
// Header byte tracker for the UDP probe monitor.
//   clk, rst    : clock, async active-high reset
//   hdr_beat    : a valid beat while the parser is in the header state
//   restart     : abort the header (runt last or error beat); index returns to 0
//   rx_data     : stream byte
//   hdr_done_c  : combinational strobe, this beat is the final header byte
//   len_q       : captured 16-bit UDP length field
module udp_hdr_len_capture
  import udp_probe_pkg::*;
#(
  parameter int unsigned HDR_BYTES  = UDP_HDR_BYTES,
  parameter int unsigned LEN_HI_IDX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hdr_beat,
  input  logic             restart,
  input  logic [7:0]       rx_data,
  output logic             hdr_done_c,
  output logic [LEN_W-1:0] len_q
);

  localparam int unsigned IDX_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

  logic [IDX_W-1:0] hdr_idx_q, hdr_idx_d;
  logic [LEN_W-1:0] len_d;

  assign hdr_done_c = hdr_beat && (hdr_idx_q == IDX_W'(HDR_BYTES - 1));

  // Index advance and length-field capture.
  always_comb begin
    hdr_idx_d = hdr_idx_q;
    len_d     = len_q;
    if (hdr_beat) begin
      if (hdr_done_c || restart) begin
        hdr_idx_d = '0;
      end else begin
        hdr_idx_d = hdr_idx_q + IDX_W'(1);
      end
      if (hdr_idx_q == IDX_W'(LEN_HI_IDX)) begin
        len_d[15:8] = rx_data;
      end
      if (hdr_idx_q == IDX_W'(LEN_HI_IDX + 1)) begin
        len_d[7:0] = rx_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_idx_q <= '0;
      len_q     <= '0;
    end else begin
      hdr_idx_q <= hdr_idx_d;
      len_q     <= len_d;
    end
  end

endmodule

// File: rtl/udp_rx_probe_monitor.sv
// Passive UDP receive-stream monitor feeding a logic-analyser core.
//   clk, rst             : clock, async active-high reset
//   rx_valid/data/last   : receive byte stream (never back-pressured)
//   rx_err               : MAC/IP error flag, sampled on every valid beat
//   stat_clr             : synchronous clear of probe0..probe2
//   probe0               : total accepted bytes (wraps)
//   probe1               : good packet count (wraps)
//   probe2               : payload length of last good packet (saturated)
//   probe3               : one-cycle pulse per bad packet
module udp_rx_probe_monitor
  import udp_probe_pkg::*;
#(
  parameter int unsigned HDR_BYTES  = UDP_HDR_BYTES,
  parameter int unsigned LEN_HI_IDX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_last,
  input  logic                   rx_err,
  input  logic                   stat_clr,
  output logic [PROBE0_W-1:0]    probe0,
  output logic [PROBE_CNT_W-1:0] probe1,
  output logic [PROBE_CNT_W-1:0] probe2,
  output logic                   probe3
);

  state_e                 state_q, state_d;
  logic [PAY_CNT_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic                   err_seen_q, err_seen_d;
  logic [PROBE0_W-1:0]    probe0_q, probe0_d;
  logic [PROBE_CNT_W-1:0] probe1_q, probe1_d;
  logic [PROBE_CNT_W-1:0] probe2_q, probe2_d;
  logic                   probe3_q, probe3_d;

  logic                   hdr_beat_c;
  logic                   hdr_restart_c;
  logic                   hdr_done_c;
  logic [LEN_W-1:0]       len_q;
  logic [PAY_CNT_W-1:0]   pay_inc_c;
  logic                   good_end_c;
  logic                   bad_end_c;
  logic [PAY_CNT_W-1:0]   pay_len_c;

  assign hdr_beat_c = rx_valid && (state_q == S_HDR);

  udp_hdr_len_capture #(
    .HDR_BYTES (HDR_BYTES),
    .LEN_HI_IDX(LEN_HI_IDX)
  ) u_hdr (
    .clk       (clk),
    .rst       (rst),
    .hdr_beat  (hdr_beat_c),
    .restart   (hdr_restart_c),
    .rx_data   (rx_data),
    .hdr_done_c(hdr_done_c),
    .len_q     (len_q)
  );

  // Payload count including the current beat, held at the 16-bit ceiling.
  assign pay_inc_c = (pay_cnt_q == '1) ? pay_cnt_q : pay_cnt_q + PAY_CNT_W'(1);

  // Packet parser: state advance and good/bad end classification.
  always_comb begin
    state_d       = state_q;
    pay_cnt_d     = pay_cnt_q;
    err_seen_d    = err_seen_q;
    hdr_restart_c = 1'b0;
    good_end_c    = 1'b0;
    bad_end_c     = 1'b0;
    pay_len_c     = '0;
    unique case (state_q)
      S_HDR: begin
        if (rx_valid) begin
          if (rx_last) begin
            // Header ending on last is a zero-payload packet; earlier is a runt.
            hdr_restart_c = 1'b1;
            err_seen_d    = 1'b0;
            if (hdr_done_c && (len_q == LEN_W'(HDR_BYTES)) && !rx_err) begin
              good_end_c = 1'b1;
            end else begin
              bad_end_c = 1'b1;
            end
          end else if (rx_err) begin
            hdr_restart_c = 1'b1;
            err_seen_d    = 1'b1;
            state_d       = S_DROP;
          end else if (hdr_done_c) begin
            pay_cnt_d = '0;
            state_d   = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (rx_valid) begin
          if (rx_last) begin
            pay_len_c  = pay_inc_c;
            pay_cnt_d  = '0;
            err_seen_d = 1'b0;
            state_d    = S_HDR;
            if (!err_seen_q && !rx_err && (len_q >= LEN_W'(HDR_BYTES)) &&
                (pay_inc_c == (len_q - LEN_W'(HDR_BYTES)))) begin
              good_end_c = 1'b1;
            end else begin
              bad_end_c = 1'b1;
            end
          end else if (rx_err) begin
            err_seen_d = 1'b1;
            state_d    = S_DROP;
          end else begin
            pay_cnt_d = pay_inc_c;
          end
        end
      end
      S_DROP: begin
        if (rx_valid && rx_last) begin
          bad_end_c  = 1'b1;
          err_seen_d = 1'b0;
          pay_cnt_d  = '0;
          state_d    = S_HDR;
        end
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  // Probe updates; a clear overrides both the byte count and a good end.
  always_comb begin
    probe0_d = probe0_q;
    probe1_d = probe1_q;
    probe2_d = probe2_q;
    probe3_d = bad_end_c;
    if (stat_clr) begin
      probe0_d = '0;
      probe1_d = '0;
      probe2_d = '0;
    end else begin
      if (rx_valid) begin
        probe0_d = probe0_q + PROBE0_W'(1);
      end
      if (good_end_c) begin
        probe1_d = probe1_q + PROBE_CNT_W'(1);
        probe2_d = sat_probe(pay_len_c);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HDR;
      pay_cnt_q  <= '0;
      err_seen_q <= 1'b0;
      probe0_q   <= '0;
      probe1_q   <= '0;
      probe2_q   <= '0;
      probe3_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pay_cnt_q  <= pay_cnt_d;
      err_seen_q <= err_seen_d;
      probe0_q   <= probe0_d;
      probe1_q   <= probe1_d;
      probe2_q   <= probe2_d;
      probe3_q   <= probe3_d;
    end
  end

  assign probe0 = probe0_q;
  assign probe1 = probe1_q;
  assign probe2 = probe2_q;
  assign probe3 = probe3_q;

endmodule

// File: tb/tb_udp_rx_probe_monitor.sv
// Scoreboard bench for udp_rx_probe_monitor: the driver pushes the expected
// probe snapshot for each packet end; a monitor pops it one edge later.
module tb_udp_rx_probe_monitor;

  typedef struct {
    logic [23:0] p0;
    logic [11:0] p1;
    logic [11:0] p2;
    logic        p3;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_last;
  logic        rx_err;
  logic        stat_clr;
  logic [23:0] probe0;
  logic [11:0] probe1;
  logic [11:0] probe2;
  logic        probe3;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   m_p0 = 0;
  int   m_p1 = 0;
  int   m_p2 = 0;

  udp_rx_probe_monitor dut (
    .clk     (clk),
    .rst     (rst),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_last (rx_last),
    .rx_err  (rx_err),
    .stat_clr(stat_clr),
    .probe0  (probe0),
    .probe1  (probe1),
    .probe2  (probe2),
    .probe3  (probe3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: on each packet-end edge pop and compare; otherwise probe3 must stay low.
  initial begin : monitor
    logic end_seen;
    exp_t e;
    forever begin
      @(posedge clk);
      end_seen = rx_valid && rx_last && !rst;
      #1;
      if (end_seen) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: packet end with no expected entry (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("sb_probe0", 32'(probe0), 32'(e.p0));
          chk("sb_probe1", 32'(probe1), 32'(e.p1));
          chk("sb_probe2", 32'(probe2), 32'(e.p2));
          chk("sb_probe3", 32'(probe3), 32'(e.p3));
        end
      end else begin
        chk("probe3_idle", 32'(probe3), 32'd0);
      end
    end
  end

  task automatic clr_cycle();
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    m_p0 = 0;
    m_p1 = 0;
    m_p2 = 0;
  endtask

  // Drives n_beats bytes: UDP header with length len_f, then incrementing payload.
  task automatic send_pkt(input logic [15:0] len_f, input int n_beats, input int err_beat,
                          input bit end_pkt, input bit clr_last, input bit gaps,
                          input bit good, input int pay);
    logic [7:0] hdr [8];
    logic [7:0] d;
    exp_t       e;
    bit         last;
    bit         clr;
    hdr[0] = 8'h12; hdr[1] = 8'h34; hdr[2] = 8'h56; hdr[3] = 8'h78;
    hdr[4] = len_f[15:8]; hdr[5] = len_f[7:0]; hdr[6] = 8'h00; hdr[7] = 8'h00;
    for (int b = 0; b < n_beats; b++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      d    = (b < 8) ? hdr[b] : 8'(b);
      last = end_pkt && (b == n_beats - 1);
      clr  = last && clr_last;
      m_p0 = clr ? 0 : ((m_p0 + 1) & 32'hFF_FFFF);
      if (last) begin
        if (clr) begin
          m_p1 = 0;
          m_p2 = 0;
        end else if (good) begin
          m_p1 = (m_p1 + 1) & 32'hFFF;
          m_p2 = (pay > 4095) ? 4095 : pay;
        end
        e.p0 = 24'(m_p0);
        e.p1 = 12'(m_p1);
        e.p2 = 12'(m_p2);
        e.p3 = !good;
        sb.push_back(e);
      end
      rx_valid = 1'b1;
      rx_data  = d;
      rx_last  = last;
      rx_err   = (b == err_beat);
      stat_clr = clr;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_last  = 1'b0;
      rx_err   = 1'b0;
      stat_clr = 1'b0;
    end
  endtask

  initial begin : driver
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_last = 1'b0; rx_err = 1'b0; stat_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_probe0", 32'(probe0), 32'd0);
    chk("rst_probe1", 32'(probe1), 32'd0);
    chk("rst_probe2", 32'(probe2), 32'd0);
    chk("rst_probe3", 32'(probe3), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good: len 12, 4 payload bytes
    send_pkt(16'h000C, 12, -1, 1, 0, 0, 1, 4);
    chk("good_probe0", 32'(probe0), 32'd12);
    chk("good_probe1", 32'(probe1), 32'd1);
    chk("good_probe2", 32'(probe2), 32'd4);

    // Length mismatch from cleared counters: len 16, 3 payload bytes
    clr_cycle();
    send_pkt(16'h0010, 11, -1, 1, 0, 0, 0, 3);
    chk("mis_probe0", 32'(probe0), 32'd11);
    chk("mis_probe1", 32'(probe1), 32'd0);
    chk("mis_probe2", 32'(probe2), 32'd0);

    // Runt, then error on payload beat 2 (S_DROP bytes still counted)
    send_pkt(16'h000C, 5, -1, 1, 0, 0, 0, 0);
    send_pkt(16'h000C, 12, 9, 1, 0, 0, 0, 0);
    chk("drop_probe0", 32'(probe0), 32'd28);
    // Error on last beat, header-only with len < 8, good header-only
    send_pkt(16'h000A, 10, 9, 1, 0, 0, 0, 2);
    send_pkt(16'h0004, 8, -1, 1, 0, 0, 0, 0);
    send_pkt(16'h0008, 8, -1, 1, 0, 0, 1, 0);
    chk("hdronly_probe1", 32'(probe1), 32'd1);

    // Wrap probe1 with 4096 zero-payload packets, then saturate probe2
    clr_cycle();
    for (int i = 0; i < 4096; i++) send_pkt(16'h0008, 8, -1, 1, 0, 0, 1, 0);
    chk("wrap_probe1", 32'(probe1), 32'd0);
    chk("wrap_probe0", 32'(probe0), 32'd32768);
    send_pkt(16'd5008, 5008, -1, 1, 0, 0, 1, 5000);
    chk("sat_probe2", 32'(probe2), 32'd4095);
    chk("sat_probe1", 32'(probe1), 32'd1);

    // Clear coincident with a good last
    send_pkt(16'h0009, 9, -1, 1, 1, 0, 1, 1);
    chk("clr_probe0", 32'(probe0), 32'd0);
    chk("clr_probe1", 32'(probe1), 32'd0);
    chk("clr_probe2", 32'(probe2), 32'd0);
    send_pkt(16'h000A, 10, -1, 1, 0, 0, 1, 2);
    chk("after_clr_probe1", 32'(probe1), 32'd1);
    chk("after_clr_probe2", 32'(probe2), 32'd2);

    // Async reset mid-payload with gaps
    send_pkt(16'h0014, 11, -1, 0, 0, 1, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_probe0", 32'(probe0), 32'd0);
    chk("arst_probe1", 32'(probe1), 32'd0);
    chk("arst_probe2", 32'(probe2), 32'd0);
    chk("arst_probe3", 32'(probe3), 32'd0);
    m_p0 = 0; m_p1 = 0; m_p2 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_pkt(16'h000B, 11, -1, 1, 0, 1, 1, 3);
    chk("post_rst_probe0", 32'(probe0), 32'd11);
    chk("post_rst_probe1", 32'(probe1), 32'd1);
    chk("post_rst_probe2", 32'(probe2), 32'd3);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
